// File: rtl/baud_tick_pkg.sv
// Shared constants and configuration record for the baud tick generator.
package baud_tick_pkg;

  localparam int DEF_INT_W  = 16;
  localparam int DEF_FRAC_W = 4;
  localparam int DEF_OSR_W  = 8;

  localparam int MIN_INT = 1;
  localparam int MIN_OSR = 1;

  typedef struct packed {
    logic [DEF_INT_W-1:0]  int_div;
    logic [DEF_FRAC_W-1:0] frac;
    logic [DEF_OSR_W-1:0]  osr;
  } baud_cfg_t;

endpackage

// File: rtl/frac_tick_counter.sv
// Oversample period counter with a fractional accumulator; the period stretches
// by one clock whenever the accumulator addition at its end will carry.
module frac_tick_counter
  import baud_tick_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic [INT_W-1:0]  int_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              tick_evt_o,
  output logic              os_tick_o
);

  logic [INT_W:0]  cnt_q, cnt_d;
  logic [INT_W:0]  last_cnt;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
  logic              os_tick_q;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac_i};
  // int_i is already clamped to >= 1, so the subtraction cannot wrap.
  assign last_cnt = {1'b0, int_i} - (INT_W+1)'(1) + {{INT_W{1'b0}}, acc_sum[FRAC_W]};

  assign tick_evt_o = !clear_i && (cnt_q == last_cnt);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d = cnt_q + (INT_W+1)'(1);
    acc_d = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (tick_evt_o) begin
      cnt_d = '0;
      acc_d = acc_sum[FRAC_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      os_tick_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      os_tick_q <= tick_evt_o;
    end
  end

  assign os_tick_o = os_tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// UART clock-enable generator: oversample, bit and mid-bit ticks with a
// double-buffered configuration that switches only on bit boundaries.
module baud_tick_gen
  import baud_tick_pkg::*;
#(
  parameter int INT_W  = DEF_INT_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OSR_W  = DEF_OSR_W
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              sync_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [INT_W-1:0]  cfg_int_i,
  input  logic [FRAC_W-1:0] cfg_frac_i,
  input  logic [OSR_W-1:0]  cfg_osr_i,
  output logic              os_tick_o,
  output logic              bit_tick_o,
  output logic              mid_tick_o,
  output logic              cfg_pending_o
);

  typedef struct packed {
    logic [INT_W-1:0]  int_div;
    logic [FRAC_W-1:0] frac;
    logic [OSR_W-1:0]  osr;
  } cfg_t;

  localparam cfg_t RESET_CFG = '{int_div: INT_W'(MIN_INT), frac: '0, osr: OSR_W'(MIN_OSR)};

  cfg_t act_q, act_d;
  cfg_t shadow_q, shadow_d;
  logic pending_q, pending_d;
  logic started_q;
  logic [OSR_W-1:0] b_q, b_d, b_next;
  logic bit_tick_q, bit_tick_d;
  logic mid_tick_q, mid_tick_d;

  logic [INT_W-1:0] n_eff;
  logic [OSR_W-1:0] r_eff;
  logic clear, tick_evt, wrap, bit_evt, apply, accept;

  assign n_eff = (act_q.int_div < INT_W'(MIN_INT)) ? INT_W'(MIN_INT) : act_q.int_div;
  assign r_eff = (act_q.osr < OSR_W'(MIN_OSR)) ? OSR_W'(MIN_OSR) : act_q.osr;

  // The first enabled edge restarts phase exactly like a sync pulse.
  assign clear = sync_i || !enable_i || !started_q;

  frac_tick_counter #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_os_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (clear),
    .int_i      (n_eff),
    .frac_i     (act_q.frac),
    .tick_evt_o (tick_evt),
    .os_tick_o  (os_tick_o)
  );

  assign wrap    = (b_q == r_eff - OSR_W'(1));
  assign b_next  = wrap ? '0 : b_q + OSR_W'(1);
  assign bit_evt = tick_evt && wrap;

  assign accept = cfg_valid_i && !pending_q;
  assign apply  = pending_q && (sync_i || !enable_i || bit_evt);

  always_comb begin
    b_d        = b_q;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    act_d      = act_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;

    if (clear) begin
      b_d = '0;
    end else if (tick_evt) begin
      b_d        = b_next;
      bit_tick_d = wrap;
      mid_tick_d = (b_next == (r_eff >> 1));
    end

    // accept and apply are mutually exclusive: one needs pending clear, the other set.
    if (apply) begin
      act_d     = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = '{int_div: cfg_int_i, frac: cfg_frac_i, osr: cfg_osr_i};
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      act_q      <= RESET_CFG;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      started_q  <= 1'b0;
      b_q        <= '0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      act_q      <= act_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      started_q  <= enable_i;
      b_q        <= b_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign bit_tick_o    = bit_tick_q;
  assign mid_tick_o    = mid_tick_q;
  assign cfg_pending_o = pending_q;
  assign cfg_ready_o   = !pending_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: a vector table of configurations with
// hand-computed tick timings, plus sequences for handshake, sync and reset.
module tb_baud_tick_gen;
  import baud_tick_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        sync;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_int;
  logic [3:0]  cfg_frac;
  logic [7:0]  cfg_osr;
  logic        os_tick;
  logic        bit_tick;
  logic        mid_tick;
  logic        cfg_pending;

  int n_checks = 0;
  int n_pass   = 0;

  baud_tick_gen dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .enable_i      (enable),
    .sync_i        (sync),
    .cfg_valid_i   (cfg_valid),
    .cfg_ready_o   (cfg_ready),
    .cfg_int_i     (cfg_int),
    .cfg_frac_i    (cfg_frac),
    .cfg_osr_i     (cfg_osr),
    .os_tick_o     (os_tick),
    .bit_tick_o    (bit_tick),
    .mid_tick_o    (mid_tick),
    .cfg_pending_o (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    baud_cfg_t cfg;
    int n_os;
    int exp_last;
    int exp_first_os;
    int exp_first_mid;
    int exp_first_bit;
    int exp_bits;
    int exp_mids;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    else n_pass++;
  endtask

  function automatic vec_t mk_vec(input int i, input int f, input int o, input int n,
                                  input int last, input int fos, input int fmid,
                                  input int fbit, input int bits, input int mids);
    vec_t v;
    v.cfg.int_div   = 16'(i);
    v.cfg.frac      = 4'(f);
    v.cfg.osr       = 8'(o);
    v.n_os          = n;
    v.exp_last      = last;
    v.exp_first_os  = fos;
    v.exp_first_mid = fmid;
    v.exp_first_bit = fbit;
    v.exp_bits      = bits;
    v.exp_mids      = mids;
    return v;
  endfunction

  // Called at a negedge; leaves enable low, config applied, at a negedge.
  task automatic load_cfg(input logic [15:0] i, input logic [3:0] f, input logic [7:0] o);
    enable = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_int   = i;
    cfg_frac  = f;
    cfg_osr   = o;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("cfg_accepted", cfg_pending, 1);
    @(negedge clk);
    check("cfg_applied", cfg_pending, 0);
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int n_os = 0, n_bits = 0, n_mids = 0, stray = 0;
    int last = -1, f_os = -1, f_mid = -1, f_bit = -1;
    load_cfg(v.cfg.int_div, v.cfg.frac, v.cfg.osr);
    enable = 1'b1;
    for (int k = 0; k <= v.exp_last + 8 && n_os < v.n_os; k++) begin
      @(negedge clk);
      if (os_tick) begin
        n_os++;
        last = k;
        if (f_os < 0) f_os = k;
        if (bit_tick) begin n_bits++; if (f_bit < 0) f_bit = k; end
        if (mid_tick) begin n_mids++; if (f_mid < 0) f_mid = k; end
      end else if (bit_tick || mid_tick) begin
        stray++;
      end
    end
    check($sformatf("v%0d_last_os", idx), last, v.exp_last);
    check($sformatf("v%0d_first_os", idx), f_os, v.exp_first_os);
    check($sformatf("v%0d_first_mid", idx), f_mid, v.exp_first_mid);
    check($sformatf("v%0d_first_bit", idx), f_bit, v.exp_first_bit);
    check($sformatf("v%0d_bits", idx), n_bits, v.exp_bits);
    check($sformatf("v%0d_mids", idx), n_mids, v.exp_mids);
    check($sformatf("v%0d_stray", idx), stray, 0);
  endtask

  initial begin
    int os_t[$], bit_t[$], mid_t[$];
    int exp_os[9];
    int f_os, f_mid, f_bit;

    reset_n   = 1'b0;
    enable    = 1'b0;
    sync      = 1'b0;
    cfg_valid = 1'b0;
    cfg_int   = '0;
    cfg_frac  = '0;
    cfg_osr   = '0;

    //          int frac osr  n  last fos fmid fbit bits mids
    vecs[0] = mk_vec(4, 0, 16, 16, 64, 4, 32, 64, 1, 1);
    vecs[1] = mk_vec(3, 8, 16, 16, 56, 3, 28, 56, 1, 1);
    vecs[2] = mk_vec(0, 0,  4,  8,  8, 1,  2,  4, 2, 2);
    vecs[3] = mk_vec(2, 0,  1,  5, 10, 2,  2,  2, 5, 5);
    vecs[4] = mk_vec(2, 0,  0,  5, 10, 2,  2,  2, 5, 5);
    vecs[5] = mk_vec(1, 15, 3,  6, 11, 1,  1,  5, 2, 2);
    vecs[6] = mk_vec(5, 4,  2,  4, 21, 5,  5, 10, 2, 2);

    // Reset state, during and after reset.
    #2;
    check("rst_os", os_tick, 0);
    check("rst_bit", bit_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_pending", cfg_pending, 0);
    check("rst_ready", cfg_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_os", os_tick, 0);
    check("post_rst_ready", cfg_ready, 1);

    for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);

    // Config change mid-bit: current bit keeps its period, second offer stalls.
    load_cfg(16'd4, 4'd0, 8'd4);
    enable = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (os_tick) os_t.push_back(k);
      if (bit_tick) bit_t.push_back(k);
      if (mid_tick) mid_t.push_back(k);
      if (k == 6) begin
        check("hs_pending_set", cfg_pending, 1);
        check("hs_ready_low", cfg_ready, 0);
      end
      if (k == 15) check("hs_pending_hold", cfg_pending, 1);
      if (k == 16) begin
        check("hs_applied_at_bit", cfg_pending, 0);
        check("hs_ready_at_bit", cfg_ready, 1);
      end
      if (k == 17) check("hs_second_accept", cfg_pending, 1);
      if (k == 5) begin cfg_valid = 1'b1; cfg_int = 16'd8; end
      if (k == 6) cfg_int = 16'd2;
      if (k == 17) cfg_valid = 1'b0;
    end
    exp_os = '{4, 8, 12, 16, 24, 32, 40, 48, 50};
    for (int j = 0; j < 9; j++)
      check($sformatf("hs_os_%0d", j), (j < os_t.size()) ? os_t[j] : -1, exp_os[j]);
    check("hs_bit_0", (bit_t.size() > 0) ? bit_t[0] : -1, 16);
    check("hs_bit_1", (bit_t.size() > 1) ? bit_t[1] : -1, 48);
    check("hs_mid_0", (mid_t.size() > 0) ? mid_t[0] : -1, 8);
    check("hs_mid_1", (mid_t.size() > 1) ? mid_t[1] : -1, 32);

    // Sync mid-bit with a pending config: tick suppressed, new phase and config.
    load_cfg(16'd4, 4'd0, 8'd8);
    enable = 1'b1;
    f_os = -1; f_mid = -1; f_bit = -1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) check("sync_pending_set", cfg_pending, 1);
      if (k == 8) check("sync_pre_tick", os_tick, 1);
      if (k == 12) begin
        check("sync_no_tick", os_tick, 0);
        check("sync_applied", cfg_pending, 0);
      end
      if (k > 12) begin
        if (os_tick && f_os < 0) f_os = k;
        if (mid_tick && f_mid < 0) f_mid = k;
        if (bit_tick && f_bit < 0) f_bit = k;
      end
      if (k == 2) begin cfg_valid = 1'b1; cfg_int = 16'd3; cfg_frac = 4'd0; cfg_osr = 8'd4; end
      if (k == 3) cfg_valid = 1'b0;
      if (k == 11) sync = 1'b1;
      if (k == 12) sync = 1'b0;
    end
    check("sync_first_os", f_os, 15);
    check("sync_first_mid", f_mid, 18);
    check("sync_first_bit", f_bit, 24);

    // Reset mid-bit with a pending config: immediate clear, defaults restored.
    load_cfg(16'd4, 4'd0, 8'd8);
    enable = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) check("rst_mid_pending_set", cfg_pending, 1);
      if (k == 8) check("rst_mid_pre_tick", os_tick, 1);
      if (k == 3) begin cfg_valid = 1'b1; cfg_int = 16'd7; end
      if (k == 4) cfg_valid = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_os", os_tick, 0);
    check("rst_mid_pending", cfg_pending, 0);
    check("rst_mid_ready", cfg_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("rst_def_os", os_tick, 1);
        check("rst_def_bit", bit_tick, 1);
        check("rst_def_mid", mid_tick, 1);
        check("rst_def_pending", cfg_pending, 0);
      end
      if (k == 2) check("rst_def_os2", os_tick, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised successor to the team's clock-enable divider for the UART datapath. It generates an oversample tick, a bit tick and a mid-bit tick from a programmable divisor with a fractional part. Avoiding a hardware divider, it takes the per-oversample period directly. Configuration is double-buffered, changes apply only on bit boundaries, and a sync input realigns phase for RX start-bit detection.

Parameters:
INT_W, 16, width of integer divisor part (clocks per oversample tick)
FRAC_W, 4, width of fractional divisor part (units of 1/2^FRAC_W clock)
OSR_W, 8, width of oversample-rate field

Ports:
clk_i  input  1  system clock
reset_n_i  input  1  asynchronous active-low reset
enable_i  input  1  run counters; low = hold counters at zero, no ticks
sync_i  input  1  one-cycle pulse: restart phase (counters and frac accumulator to zero)
cfg_valid_i  input  1  new configuration offered
cfg_ready_o  output  1  shadow register free; handshake when valid&ready
cfg_int_i  input  INT_W  integer clocks per oversample tick
cfg_frac_i  input  FRAC_W  fractional clocks per oversample tick
cfg_osr_i  input  OSR_W  oversample ticks per bit
os_tick_o  output  1  one-cycle oversample enable
bit_tick_o  output  1  one-cycle bit-boundary enable
mid_tick_o  output  1  one-cycle mid-bit enable
cfg_pending_o  output  1  accepted config not yet applied

Behaviour:
- Reset (async, reset_n_i low): active config int=1, frac=0, osr=1; all counters, frac accumulator and shadow cleared; all tick outputs 0; cfg_pending_o=0; cfg_ready_o=1.
- All outputs registered; no combinational path from input to output.
- Effective int N = max(cfg int, 1); effective osr R = max(cfg osr, 1).
- Oversample period: cnt counts 0..P-1, where P = N, or N+1 when the frac accumulator carries. os_tick_o is high the cycle after cnt reaches P-1. Exactly one cycle wide.
- Frac accumulator (FRAC_W bits): on each os tick, acc <= acc + frac (mod 2^FRAC_W). The carry-out selects P=N+1 for the next period. Average period = N + frac/2^FRAC_W.
- Bit counter b counts 0..R-1 on os ticks. bit_tick_o coincides with the os_tick that wraps b from R-1 to 0. mid_tick_o coincides with the os_tick where b reaches floor(R/2). For R=1, all three ticks coincide.
- Start alignment: after reset release, enable_i rise or sync_i, the first os_tick_o occurs P cycles after the sampling edge.
- enable_i low: counters, b and acc held at 0; ticks 0; cfg handshake still works.
- Config handshake:
  - cfg_ready_o = !cfg_pending_o.
  - valid&ready loads the shadow and sets pending next cycle.
  - Pending shadow is applied, and pending cleared, at the first of: the bit_tick boundary edge, enable_i low, or sync_i.
  - Applying never shortens or stretches the current bit.
- Simultaneous events:
  - sync_i wins over tick generation: no tick that cycle, counters cleared, pending applied.
  - cfg accept in the same cycle as an apply boundary is taken into the shadow and waits for the next boundary.
- Reset mid-operation returns immediately to reset state; a pending config is discarded.
- Widths: cnt is INT_W+1 bits, so P = 2^INT_W-1+1 does not overflow. b is OSR_W bits.

Decomposition:
- Package baud_tick_pkg: default widths, MIN_INT=1, MIN_OSR=1 constants, config struct type {int, frac, osr}.
- One sub-module: frac_tick_counter (cnt plus frac accumulator, producing os_tick). baud_tick_gen adds the bit counter, shadow config and handshake.

Test Plan:
- int=4, frac=0, osr=16, enable held -> os_tick every 4 clocks, bit_tick every 64, mid_tick at the 8th os_tick of each bit (clock 32 after start).
- int=3, frac=8 (3.5) -> os periods alternate 3,4; 16 os_ticks in exactly 56 clocks; int=0 behaves as int=1 (tick every clock).
- Config int=4 -> 8 accepted mid-bit -> cfg_pending_o=1 and cfg_ready_o=0 until bit_tick; that bit keeps 4-clock periods, the next uses 8; a second valid is stalled while pending.
- sync_i pulsed mid-bit with pending config -> no tick that cycle, pending cleared, first os_tick P clocks later, mid_tick at R/2 os_ticks.
- osr=1 and osr=0 -> bit_tick, mid_tick and os_tick coincident on every os tick.
- reset_n_i asserted mid-bit with pending config -> outputs 0 immediately; after release, config back to int=1, osr=1, pending 0.
